bit32_skid_stage: RTL and testbench
===================================

Name: bit32_skid_stage

Overview:
Registered 32-bit transfer stage with a valid/ready handshake on both sides. It replaces a plain combinational pass-through wherever a pipeline boundary needs a cut, for example between IF/ID or ID/EX in the MIPS32 datapath. A two-entry skid buffer keeps full throughput (one word per cycle) while both data and in_ready leave the block from flops. A flush input drops all buffered words on branch or jump redirects.

Parameters:
WIDTH, 32, data word width in bits.
FLUSH_DROPS_INPUT, 1, 1 = a word offered in the same cycle as flush is discarded; 0 = that word is kept and becomes the only entry.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all buffered entries.
in_valid  input  1  upstream word valid.
in_ready  output  1  stage can accept a word; registered.
in_data  input  WIDTH  upstream word.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  downstream accepts the word.
out_data  output  WIDTH  head word; registered.
occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- While rst_n = 0: state = EMPTY, out_valid = 0, in_ready = 1, out_data = 0, skid data = 0, occupancy = 0. Deassertion takes effect at the next clk edge.
- Definitions: accept = in_valid & in_ready. drain = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- States and occupancy: EMPTY (0), ONE (1, main valid), TWO (2, main and skid valid).
- Registered outputs: in_ready = (state != TWO). out_valid = (state != EMPTY).
- EMPTY:
  - accept -> main <= in_data, go to ONE.
- ONE:
  - accept & drain -> main <= in_data, stay in ONE.
  - accept & !drain -> skid <= in_data, go to TWO.
  - !accept & drain -> go to EMPTY.
  - otherwise hold.
- TWO (in_ready = 0, so no accept is possible):
  - drain -> main <= skid, go to ONE.
  - otherwise hold.
- Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle whenever out_ready is held high.
- Ordering is strictly FIFO. No word is duplicated or lost except by flush.
- Stability: while out_valid & !out_ready, out_data and out_valid must not change.
- in_data is ignored when in_valid = 0 or in_ready = 0.
- Flush has priority over every other event. At the next edge:
  - state goes to EMPTY and occupancy to 0.
  - Exception: if FLUSH_DROPS_INPUT = 0 and accept was true in the flush cycle, that word loads into main and the state goes to ONE.
  - A drain in the flush cycle still counts as completed downstream.
- Data register contents are don't-care when not valid. They are not cleared by flush.
- Reset asserted mid-transfer: all entries are lost and outputs take their reset values immediately.

Decomposition:
- Shared package (mips_pipe_pkg):
  - state enum with EMPTY/ONE/TWO encoded as 2'b00/01/10; occupancy equals the state code.
  - WIDTH default constant DATA_W = 32.
- One sub-module is natural: bit32_en_reg, a WIDTH-bit register with load enable and async active-low reset to 0. It is instantiated twice, for main and skid.
- The control FSM stays in the top module.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, in_ready = 1, out_data = 0x00000000, occupancy = 0 throughout.
- Streaming: out_ready = 1, drive 0x00000001..0x00000008 on consecutive cycles -> same sequence on out_data one cycle later, in_ready constantly 1, occupancy constantly 1.
- Backpressure: send 0xDEADBEEF then 0xCAFEF00D with out_ready = 0 -> occupancy = 2 and in_ready = 0. Then send 0x12345678 offered for 3 cycles and raise out_ready -> outputs appear in order 0xDEADBEEF, 0xCAFEF00D, 0x12345678; out_data stable during the stall.
- Flush in TWO: fill with 0xAAAA0000 and 0xBBBB0000, assert flush for 1 cycle with in_valid = 1 and in_data = 0xCCCC0000 -> next cycle occupancy = 0, out_valid = 0, in_ready = 1. With FLUSH_DROPS_INPUT = 0 in a separate run (flush asserted while in ONE, so in_ready = 1) -> occupancy = 1, out_data = 0xCCCC0000.
- Async reset mid-operation: occupancy = 2, drop rst_n between clock edges -> out_valid falls and in_ready rises without waiting for a clk edge. After release, the first new word 0x00000042 emerges with latency 1.
- Random: 10k cycles of random in_valid, out_ready and flush, checked against a reference queue model -> no loss or reordering, occupancy never exceeds 2.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS32 pipeline boundary stages.
//   skid_state_e : skid stage fill state; the encoding equals the entry count,
//                  so the state register doubles as the occupancy output.
//   DATA_W       : default datapath word width.
package mips_pipe_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_e;

endpackage

// File: rtl/bit32_en_reg.sv
// Data register with load enable, cleared to zero by reset.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   en    : load enable
//   d     : next value
//   q     : registered value
module bit32_en_reg
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bit32_skid_stage.sv
// Registered valid/ready pipeline cut with a two-entry skid buffer.
// Full throughput is kept while in_ready and out_data both come from flops.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : drop all buffered words at the next edge
//   in_valid/in_ready     : upstream handshake (in_ready registered)
//   in_data               : upstream word
//   out_valid/out_ready   : downstream handshake
//   out_data              : head word (registered, main register)
//   occupancy             : number of held words, 0..2
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | nothing held, out_valid = 0
// ONE   | main register holds the head word
// TWO   | main holds head, skid holds the next word; in_ready = 0
module bit32_skid_stage
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH             = DATA_W,
  parameter bit FLUSH_DROPS_INPUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e      state, state_nxt;
  logic             accept, drain;
  logic             main_ld, skid_ld, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Handshake outputs are computed from the next state so they leave the
  // block straight from flops instead of through a state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      // In TWO in_ready is low, so accept can only be true from EMPTY/ONE.
      if (!FLUSH_DROPS_INPUT && accept) begin
        state_nxt = ONE;
      end else begin
        state_nxt = EMPTY;
      end
    end else begin
      unique case (state)
        EMPTY: if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !drain) begin
            state_nxt = TWO;
          end else if (!accept && drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO:     if (drain) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      main_ld = accept & !FLUSH_DROPS_INPUT;
    end else begin
      unique case (state)
        EMPTY: main_ld = accept;
        ONE: begin
          main_ld = accept & drain;
          skid_ld = accept & !drain;
        end
        TWO: begin
          main_ld        = drain;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign main_d    = main_from_skid ? skid_q : in_data;
  assign occupancy = state;

  bit32_en_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_ld),
    .d     (main_d),
    .q     (out_data)
  );

  bit32_en_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_ld),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_bit32_skid_stage.sv
// Directed and random checks of the skid stage. Two instances share all
// inputs: dut0 drops a word offered with flush, dut1 keeps it.
module tb_bit32_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [1:0]  occ0, occ1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  bit32_skid_stage #(.WIDTH(32), .FLUSH_DROPS_INPUT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  bit32_skid_stage #(.WIDTH(32), .FLUSH_DROPS_INPUT(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [1:0] occ, input logic ov,
                      input logic ir, input logic [31:0] od, input logic check_data);
    chk({tag, ".occ"},  32'(occ0),       32'(occ));
    chk({tag, ".ov"},   32'(out_valid0), 32'(ov));
    chk({tag, ".ir"},   32'(in_ready0),  32'(ir));
    if (check_data) chk({tag, ".data"}, out_data0, od);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag, input logic [1:0] occ, input logic ov,
                           input logic ir, input logic [31:0] od, input int sz,
                           input logic [31:0] head);
    chk({tag, ".occ"}, 32'(occ), 32'(sz));
    chk({tag, ".ov"},  32'(ov),  32'(sz > 0));
    chk({tag, ".ir"},  32'(ir),  32'(sz < 2));
    if (sz > 0) chk({tag, ".data"}, od, head);
  endtask

  initial begin
    bit a0, a1, r0, r1;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;

    // reset held with a word offered
    for (int i = 0; i < 3; i++) begin
      tick();
      chk0("reset", 2'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    end
    chk("reset.dut1.occ", 32'(occ1), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk0("post_reset", 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      chk0("stream", 2'd1, 1'b1, 1'b1, 32'(i), 1'b1);
    end
    in_valid = 1'b0;
    tick();
    chk0("stream_end", 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hDEADBEEF;
    tick();
    chk0("bp1", 2'd1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    in_data = 32'hCAFEF00D;
    tick();
    chk0("bp2", 2'd2, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    in_data = 32'h12345678;
    tick();
    chk0("bp_stall1", 2'd2, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    tick();
    chk0("bp_stall2", 2'd2, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    out_ready = 1'b1;
    tick();
    chk0("bp_drain1", 2'd1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    tick();
    chk0("bp_drain2", 2'd1, 1'b1, 1'b1, 32'h12345678, 1'b1);
    in_valid = 1'b0;
    tick();
    chk0("bp_empty", 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);

    // flush while TWO: nothing can be accepted, both variants empty
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hAAAA0000;
    tick();
    in_data = 32'hBBBB0000;
    tick();
    chk0("fl_two_fill", 2'd2, 1'b1, 1'b0, 32'hAAAA0000, 1'b1);
    flush = 1'b1; in_data = 32'hCCCC0000;
    tick();
    chk0("fl_two", 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("fl_two.dut1.occ", 32'(occ1), 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // flush while ONE with a word offered
    in_valid = 1'b1; in_data = 32'hAAAA0000;
    tick();
    chk0("fl_one_fill", 2'd1, 1'b1, 1'b1, 32'hAAAA0000, 1'b1);
    flush = 1'b1; in_data = 32'hCCCC0000;
    tick();
    chk0("fl_one.dut0", 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("fl_one.dut1.occ",  32'(occ1), 32'd1);
    chk("fl_one.dut1.ov",   32'(out_valid1), 32'd1);
    chk("fl_one.dut1.data", out_data1, 32'hCCCC0000);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_one.dut1.drained", 32'(occ1), 32'd0);

    // async reset between edges while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    chk0("ar_full", 2'd2, 1'b1, 1'b0, 32'h1, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk0("ar_async", 2'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 32'h42; out_ready = 1'b1;
    tick();
    chk0("ar_first", 2'd1, 1'b1, 1'b1, 32'h42, 1'b1);
    in_valid = 1'b0;
    tick();
    chk0("ar_empty", 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);

    // random traffic against queue models of both variants
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      a0 = in_valid && (q0.size() < 2);
      r0 = (q0.size() > 0) && out_ready;
      a1 = in_valid && (q1.size() < 2);
      r1 = (q1.size() > 0) && out_ready;
      if (flush) begin
        q0.delete();
        q1.delete();
        if (a1) q1.push_back(in_data);
      end else begin
        if (r0) void'(q0.pop_front());
        if (a0) q0.push_back(in_data);
        if (r1) void'(q1.pop_front());
        if (a1) q1.push_back(in_data);
      end
      tick();
      chk_model("rnd0", occ0, out_valid0, in_ready0, out_data0, q0.size(),
                (q0.size() > 0) ? q0[0] : 32'h0);
      chk_model("rnd1", occ1, out_valid1, in_ready1, out_data1, q1.size(),
                (q1.size() > 0) ? q1[0] : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
